// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and operand-stage state enums for the ALU and its operand stage
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        GET_A  = 2'b00,
        GET_B  = 2'b01,
        GET_OP = 2'b10,
        ISSUE  = 2'b11
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational W-bit ALU (AND/OR/XOR/wrapping ADD) fed by alu_operand_stage
module alu
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic [1:0]   op,
    output logic [W-1:0] ans
);

    // ADD keeps only the low W bits; the carry out is intentionally dropped.
    always_comb begin
        ans = '0;
        case (op_t'(op))
            OP_AND:  ans = inA & inB;
            OP_OR:   ans = inA | inB;
            OP_XOR:  ans = inA ^ inB;
            OP_ADD:  ans = inA + inB;
            default: ans = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - collects A/B/opcode beats, issues them to the ALU and captures the result; optional ALU_OPERAND_STAGE_CHAIN_EN
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_ans,
    output logic [W-1:0] res,
    output logic         res_valid
`ifdef ALU_OPERAND_STAGE_CHAIN_EN
    ,
    input  logic         chain
`endif
);

    state_t state;
    state_t state_nx;
    logic   accept;
    logic   chain_load;

    // Chaining reuses the previous result as operand A without taking a beat.
`ifdef ALU_OPERAND_STAGE_CHAIN_EN
    assign chain_load = (state == GET_A) && chain;
`else
    assign chain_load = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= GET_A;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            GET_A:   if (chain_load || accept) state_nx = GET_B;
            GET_B:   if (accept) state_nx = GET_OP;
            GET_OP:  if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = GET_A;
            default: state_nx = GET_A;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state)
            GET_A:   in_ready = !chain_load;
            GET_B:   in_ready = 1'b1;
            GET_OP:  in_ready = 1'b1;
            ISSUE:   in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'b00;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                GET_A: begin
                    if (chain_load) begin
                        alu_a <= res;
                    end else if (accept) begin
                        alu_a <= in_data;
                    end
                end
                GET_B: begin
                    if (accept) alu_b <= in_data;
                end
                GET_OP: begin
                    if (accept) alu_op <= in_data[1:0];
                end
                ISSUE: begin
                    res       <= alu_ans;
                    res_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed-vector bench for alu_operand_stage driving the shared ALU
module tb_alu_operand_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_ans;
    logic [3:0] res;
    logic       res_valid;
    logic       chain;

    int n_vec;
    int n_err;

    alu_operand_stage #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_ans   (alu_ans),
        .res       (res),
        .res_valid (res_valid)
`ifdef ALU_OPERAND_STAGE_CHAIN_EN
        ,
        .chain     (chain)
`endif
    );

    alu #(.W(4)) u_alu (
        .inA (alu_a),
        .inB (alu_b),
        .op  (alu_op),
        .ans (alu_ans)
    );

    always #5 clk = ~clk;

    // Starts and ends on a falling edge; the beat is taken at the rising edge in between.
    task automatic send(input logic [3:0] d);
        int wait_cnt;
        in_valid = 1'b1;
        in_data  = d;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_vec++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op_beat, input logic [3:0] exp);
        send(a);
        send(b);
        send(op_beat);
        n_vec++;
        if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_issue: in_ready=%b res_valid=%b required 0 0", name, in_ready, res_valid);
        end
        n_vec++;
        if (alu_a !== a || alu_b !== b || alu_op !== op_beat[1:0]) begin
            n_err++;
            $display("FAIL %s_operands: a=%h b=%h op=%h required %h %h %h",
                     name, alu_a, alu_b, alu_op, a, b, op_beat[1:0]);
        end
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b1 || res !== exp) begin
            n_err++;
            $display("FAIL %s_result: res_valid=%b res=%h required 1 %h", name, res_valid, res, exp);
        end
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0 || res !== exp || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_hold: res_valid=%b res=%h in_ready=%b required 0 %h 1",
                     name, res_valid, res, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h7;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b res_valid=%b required 1 0", in_ready, res_valid);
        end
        n_vec++;
        if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 2'b00 || res !== 4'h0) begin
            n_err++;
            $display("FAIL reset_regs: a=%h b=%h op=%h res=%h required 0 0 0 0", alu_a, alu_b, alu_op, res);
        end
    endtask

    task automatic test_basic();
        do_op("add_2_3", 4'h2, 4'h3, 4'h3, 4'h5);
    endtask

    task automatic test_ops();
        do_op("add_wrap", 4'hF, 4'h1, 4'h3, 4'h0);
        do_op("and",      4'hC, 4'hA, 4'h0, 4'h8);
        do_op("or",       4'hC, 4'hA, 4'h1, 4'hE);
        do_op("xor",      4'hC, 4'hA, 4'h2, 4'h6);
        do_op("xor_upper_ignored", 4'hC, 4'hA, 4'hE, 4'h6);
    endtask

    task automatic test_back_to_back();
        logic [3:0] beats [9];
        int idx;
        int pulses;
        int ready_low;
        beats = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h0, 4'h7, 4'h1, 4'h2};
        idx = 0;
        pulses = 0;
        ready_low = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 12) begin
                n_vec++;
                if (in_ready !== ((c % 4) != 3)) begin
                    n_err++;
                    $display("FAIL b2b_ready_c%0d: in_ready=%b required %b", c, in_ready, (c % 4) != 3);
                end
                if (!in_ready) ready_low++;
            end
            n_vec++;
            if (res_valid !== (c == 4 || c == 8 || c == 12)) begin
                n_err++;
                $display("FAIL b2b_valid_c%0d: res_valid=%b required %b", c, res_valid, (c == 4 || c == 8 || c == 12));
            end
            if (res_valid) begin
                pulses++;
                n_vec++;
                if (res !== (c == 4 ? 4'h3 : (c == 8 ? 4'h4 : 4'h6))) begin
                    n_err++;
                    $display("FAIL b2b_res_c%0d: res=%h", c, res);
                end
            end
            in_valid = (idx < 9);
            in_data  = (idx < 9) ? beats[idx] : 4'h0;
            if (in_valid && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_vec++;
        if (pulses != 3 || ready_low != 3 || idx != 9) begin
            n_err++;
            $display("FAIL b2b_counts: pulses=%0d ready_low=%0d beats=%0d required 3 3 9", pulses, ready_low, idx);
        end
    endtask

    task automatic test_gaps_reset();
        send(4'h6);
        repeat (3) @(negedge clk);
        n_vec++;
        if (alu_a !== 4'h6 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gap_hold_a: a=%h in_ready=%b res_valid=%b required 6 1 0", alu_a, in_ready, res_valid);
        end
        send(4'h7);
        repeat (2) @(negedge clk);
        n_vec++;
        if (alu_b !== 4'h7 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL gap_hold_b: b=%h in_ready=%b required 7 1", alu_b, in_ready);
        end
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        n_vec++;
        if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 2'b00 || res !== 4'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midop_reset: a=%h b=%h op=%h res=%h in_ready=%b required 0 0 0 0 1",
                     alu_a, alu_b, alu_op, res, in_ready);
        end
        do_op("after_reset", 4'h9, 4'h5, 4'h3, 4'hE);
    endtask

`ifdef ALU_OPERAND_STAGE_CHAIN_EN
    task automatic test_chain();
        do_op("chain_seed", 4'h2, 4'h3, 4'h3, 4'h5);
        chain = 1'b1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL chain_ready: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        chain = 1'b0;
        n_vec++;
        if (alu_a !== 4'h5 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL chain_load: a=%h in_ready=%b required 5 1", alu_a, in_ready);
        end
        send(4'h1);
        send(4'h3);
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b1 || res !== 4'h6) begin
            n_err++;
            $display("FAIL chain_result: res_valid=%b res=%h required 1 6", res_valid, res);
        end
    endtask
`endif

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        chain    = 1'b0;
        n_vec    = 0;
        n_err    = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ops();
        test_back_to_back();
        test_gaps_reset();
`ifdef ALU_OPERAND_STAGE_CHAIN_EN
        test_chain();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
